// File: rtl/matrix_io_controller_if.sv
// matrix_io_controller_if: byte-wide load and result stream handshakes between the pins and the controller.
interface matrix_io_controller_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_valid);
  modport slave  (input in_data, in_valid, out_ready, output in_ready, out_data, out_valid);
endinterface

// File: rtl/matrix_io_controller.sv
// matrix_io_controller: loads A/B byte-wise, pulses the multiply unit, waits for done
// with a timeout, then streams the 64-bit result back out byte-wise.
module matrix_io_controller #(
  parameter int TIMEOUT_CYCLES = 128,
  parameter int CNT_W          = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  matrix_io_controller_if.slave       io,
  output logic [63:0]                 mmu_matrixA,
  output logic [63:0]                 mmu_matrixB,
  output logic                        mmu_enable,
  input  logic [63:0]                 mmu_result,
  input  logic                        mmu_listo,
  output logic                        done,
  output logic                        error
);
  typedef enum logic [2:0] {S_LOAD_A, S_LOAD_B, S_START, S_WAIT, S_SEND} state_t;
  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d, cnt_nxt;
  logic [CNT_W-1:0]  tcnt_q, tcnt_d;
  logic [63:0]       a_q, a_d, b_q, b_d, res_q, res_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d, en_q, en_d, done_q, done_d, err_q, err_d;
  assign cnt_nxt      = cnt_q + 3'd1;
  assign io.in_ready  = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
  assign io.out_data  = out_data_q;
  assign io.out_valid = out_valid_q;
  assign mmu_matrixA  = a_q;
  assign mmu_matrixB  = b_q;
  assign mmu_enable   = en_q;
  assign done         = done_q;
  assign error        = err_q;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tcnt_d      = tcnt_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    en_d        = 1'b0;
    done_d      = 1'b0;
    err_d       = err_q;
    case (state_q)
      S_LOAD_A, S_LOAD_B: if (io.in_valid) begin
        cnt_d = cnt_nxt;
        if (state_q == S_LOAD_A) a_d[{cnt_q, 3'b000} +: 8] = io.in_data;
        else b_d[{cnt_q, 3'b000} +: 8] = io.in_data;
        // first byte of a new job clears a stale timeout
        if (state_q == S_LOAD_A && cnt_q == 3'd0) err_d = 1'b0;
        if (cnt_q == 3'd7) begin
          state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_START;
          en_d    = (state_q == S_LOAD_B);
        end
      end
      S_START: begin
        tcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        tcnt_d = tcnt_q + 1'b1;
        if (mmu_listo) begin
          res_d       = mmu_result;
          out_data_d  = mmu_result[7:0];
          out_valid_d = 1'b1;
          state_d     = S_SEND;
        end else if (tcnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = S_LOAD_A;
        end
      end
      S_SEND: if (io.out_ready) begin
        cnt_d      = cnt_nxt;
        out_data_d = res_q[{cnt_nxt, 3'b000} +: 8];
        if (cnt_q == 3'd7) begin
          out_valid_d = 1'b0;
          done_d      = 1'b1;
          state_d     = S_LOAD_A;
        end
      end
      default: state_d = S_LOAD_A;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_LOAD_A;
      cnt_q       <= '0;
      tcnt_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      en_q        <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tcnt_q      <= tcnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      en_q        <= en_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end
endmodule
